// File: rtl/fp_align_shift.sv
// Multi-cycle significand alignment for the FP adder: shifts the smaller significand
// right by up to STEP bits per cycle and collects guard/round/sticky. Option: FP_ALIGN_FASTSAT_EN.
module fp_align_shift #(
    parameter int SIG_BITS = 23,
    parameter int EXP_BITS = 8,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIG_BITS-1:0] sig1_swap,
    input  logic [SIG_BITS-1:0] sig2_swap,
    input  logic                hid1,
    input  logic                hid2,
    input  logic [EXP_BITS-1:0] shift,
    input  logic                swap,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIG_BITS:0]   big_sig,
    output logic [SIG_BITS:0]   small_sig,
    output logic                guard,
    output logic                round,
    output logic                sticky,
    output logic                swap_out
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // SHIFT | shifting W by min(rem, STEP) per cycle
    // DONE  | result held, out_valid high until out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int WW = SIG_BITS + 4;
    localparam logic [EXP_BITS-1:0] STEP_E = EXP_BITS'(STEP);

    state_t              state, state_nxt;
    logic [WW-1:0]       w_reg, w_nxt, w_shifted;
    logic [EXP_BITS-1:0] rem, rem_nxt, k;
    logic [SIG_BITS:0]   big_reg;
    logic                swap_reg;
    logic                lost;
    logic                accept;

`ifdef FP_ALIGN_FASTSAT_EN
    localparam int SAT_SHIFT = SIG_BITS + 4;
    logic sat_reg;
`endif

    assign accept = in_valid && (state == IDLE);

    // One shift step; everything falling off the bottom (old bit 0 included) folds into sticky.
    always_comb begin
        k         = (rem < STEP_E) ? rem : STEP_E;
        w_shifted = w_reg >> k;
        lost      = |(w_reg & ~({WW{1'b1}} << k));
        w_nxt     = {w_shifted[WW-1:1], w_shifted[0] | lost};
        rem_nxt   = rem - k;
`ifdef FP_ALIGN_FASTSAT_EN
        if (sat_reg) begin
            w_nxt   = {{(WW-1){1'b0}}, |w_reg};
            rem_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (shift == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg    <= '0;
            rem      <= '0;
            big_reg  <= '0;
            swap_reg <= 1'b0;
`ifdef FP_ALIGN_FASTSAT_EN
            sat_reg  <= 1'b0;
`endif
        end else if (accept) begin
            w_reg    <= {hid2, sig2_swap, 3'b000};
            rem      <= shift;
            big_reg  <= {hid1, sig1_swap};
            swap_reg <= swap;
`ifdef FP_ALIGN_FASTSAT_EN
            sat_reg  <= (32'(shift) >= SAT_SHIFT);
`endif
        end else if (state == SHIFT) begin
            w_reg <= w_nxt;
            rem   <= rem_nxt;
        end
    end

    assign big_sig   = big_reg;
    assign swap_out  = swap_reg;
    assign small_sig = w_reg[WW-1:3];
    assign guard     = w_reg[2];
    assign round     = w_reg[1];
    assign sticky    = w_reg[0];

endmodule
